// File: rtl/rkey_sched256.sv
// Round-key scheduler: captures a 256-bit key, stores the 15 expanded round keys and
// replays them forward (encrypt) or reverse (decrypt). Key reuse: RKEY_SCHED_REUSE_EN.
module rkey_sched256 #(
   parameter int KX_IDX_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [0:255] key,
   input  logic         key_vld,
   output logic         key_rdy,
   output logic         tbl_vld,
   input  logic         start,
   input  logic         dir,
   output logic         start_rdy,
   output logic [0:127] rk,
   output logic         rk_vld,
   input  logic         rk_rdy,
   output logic         rk_last,
   output logic [0:255] kx_kt,
   output logic         kx_kt_vld,
   input  logic         kx_kt_rdy,
   input  logic [0:127] kx_rkey,
   input  logic         kx_rkey_vld,
   input  logic         kx_rkey_last,
   output logic         seq_err,
   output logic [1:0]   dbg_state_o
);

   // All streams are valid/ready: a transfer happens on a rising edge where both are
   // high, and a source holds valid and payload steady until ready is seen.
   typedef enum logic [1:0] {EMPTY, LOAD, READY, STREAM} state_e;

   localparam logic [KX_IDX_W-1:0] IDX_LAST = KX_IDX_W'(14);
   localparam logic [KX_IDX_W-1:0] IDX_ONE  = KX_IDX_W'(1);

   state_e              state_q, state_d;
   logic [0:255]        key_q, key_d;
   logic [KX_IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [KX_IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic                dir_q, dir_d;
   logic                tbl_vld_q, tbl_vld_d;
   logic                seq_err_q, seq_err_d;
   logic                tbl_we;
   logic                key_same;
   logic [0:127]        tbl [0:14];

   // The expander needs no explicit ready check: its first round key doubles as accept.
   logic unused_kx_kt_rdy;
   assign unused_kx_kt_rdy = kx_kt_rdy;

`ifdef RKEY_SCHED_REUSE_EN
   assign key_same = (key == key_q);
`else
   assign key_same = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EMPTY;
         key_q     <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         dir_q     <= 1'b0;
         tbl_vld_q <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         dir_q     <= dir_d;
         tbl_vld_q <= tbl_vld_d;
         seq_err_q <= seq_err_d;
      end
   end

   // Table contents are deliberately left unreset; tbl_vld qualifies them.
   always_ff @(posedge clk) begin
      if (tbl_we) tbl[wr_idx_q] <= kx_rkey;
   end

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      dir_d     = dir_q;
      tbl_vld_d = tbl_vld_q;
      seq_err_d = seq_err_q;
      tbl_we    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (key_vld) begin
               key_d    = key;
               wr_idx_d = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (kx_rkey_vld) begin
               tbl_we   = 1'b1;
               wr_idx_d = (wr_idx_q == IDX_LAST) ? '0 : wr_idx_q + IDX_ONE;
               if (wr_idx_q == IDX_LAST && kx_rkey_last) begin
                  tbl_vld_d = 1'b1;
                  state_d   = READY;
               end else if (kx_rkey_last || wr_idx_q == IDX_LAST) begin
                  seq_err_d = 1'b1;
                  tbl_vld_d = 1'b0;
                  state_d   = EMPTY;
               end
            end
         end
         READY: begin
            if (start) begin
               dir_d    = dir;
               rd_idx_d = dir ? IDX_LAST : '0;
               state_d  = STREAM;
            end else if (key_vld && !key_same) begin
               tbl_vld_d = 1'b0;
               key_d     = key;
               wr_idx_d  = '0;
               state_d   = LOAD;
            end
         end
         STREAM: begin
            if (rk_rdy) begin
               if (rk_last) state_d = READY;
               else if (dir_q) rd_idx_d = rd_idx_q - IDX_ONE;
               else rd_idx_d = rd_idx_q + IDX_ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      key_rdy     = (state_q == EMPTY) || (state_q == READY && !start);
      start_rdy   = (state_q == READY);
      rk_vld      = (state_q == STREAM);
      rk_last     = rk_vld && (rd_idx_q == (dir_q ? '0 : IDX_LAST));
      rk          = rk_vld ? tbl[rd_idx_q] : '0;
      kx_kt_vld   = (state_q == LOAD) && (wr_idx_q == '0);
      kx_kt       = key_q;
      tbl_vld     = tbl_vld_q;
      seq_err     = seq_err_q;
      dbg_state_o = state_q;
   end

endmodule
